// File: rtl/lc3_decode.sv
// lc3_decode: LC-3 decode stage. Captures the fetched instruction and its
// next-PC on enable_decode, and registers the execute / writeback / memory
// control words derived from the opcode. All outputs hold while stalled.
//
// Optional feature macro: DECODE_INSTR_CNT_EN adds a 16-bit instr_count
// output counting capture edges, illegal opcodes included, wrapping at 0xFFFF.
//
// Capture handshake: enable_decode is a one-sided strobe from fetch. Every
// rising edge with reset high and enable_decode=1 loads one instruction;
// there is no back-pressure, so back-to-back strobes capture one word per cycle.
module lc3_decode (
  input  logic        clock,
  input  logic        reset,          // synchronous, active-low
  input  logic        enable_decode,
  input  logic [15:0] instr_dout,
  input  logic [15:0] npc_in,
  output logic [15:0] ir,
  output logic [15:0] npc_out,
  output logic [5:0]  E_control,
  output logic [1:0]  W_control,
  output logic        mem_control,
  output logic        decode_valid,
`ifdef DECODE_INSTR_CNT_EN
  output logic        illegal_op,
  output logic [15:0] instr_count
`else
  output logic        illegal_op
`endif
);

  // Opcode encodings
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  // Writeback select encodings
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PCR = 2'b10;

  logic [15:0] ir_q, ir_d;
  logic [15:0] npc_q, npc_d;
  logic [5:0]  e_ctl_q, e_ctl_d;
  logic [1:0]  w_ctl_q, w_ctl_d;
  logic        mem_ctl_q, mem_ctl_d;
  logic        valid_q, valid_d;
  logic        illegal_q, illegal_d;

  // Decoded controls for the incoming word (pure function of instr_dout)
  logic [5:0]  e_dec;
  logic [1:0]  w_dec;
  logic        m_dec;
  logic        ill_dec;
  logic        op2_reg;

  // Register-operand select for ADD/AND: bit5 clear means SR2 is a register
  assign op2_reg = ~instr_dout[5];

  // Opcode decode table
  always_comb begin
    e_dec   = 6'b000000;
    w_dec   = WB_ALU;
    m_dec   = 1'b0;
    ill_dec = 1'b0;
    case (instr_dout[15:12])
      OP_ADD: e_dec = {5'b00000, op2_reg};
      OP_AND: e_dec = {5'b01000, op2_reg};
      OP_NOT: e_dec = 6'b100000;
      OP_BR:  e_dec = 6'b000110;
      OP_JMP: e_dec = 6'b001100;
      OP_LD:  begin e_dec = 6'b000110; w_dec = WB_MEM; end
      OP_LDR: begin e_dec = 6'b001000; w_dec = WB_MEM; end
      OP_LDI: begin e_dec = 6'b000110; w_dec = WB_MEM; m_dec = 1'b1; end
      OP_LEA: begin e_dec = 6'b000110; w_dec = WB_PCR; end
      OP_ST:  e_dec = 6'b000110;
      OP_STR: e_dec = 6'b001000;
      OP_STI: begin e_dec = 6'b000110; m_dec = 1'b1; end
      default: ill_dec = 1'b1;
    endcase
  end

  // Next-state: load everything on a capture, otherwise hold
  always_comb begin
    ir_d      = ir_q;
    npc_d     = npc_q;
    e_ctl_d   = e_ctl_q;
    w_ctl_d   = w_ctl_q;
    mem_ctl_d = mem_ctl_q;
    valid_d   = valid_q;
    illegal_d = illegal_q;
    if (enable_decode) begin
      ir_d      = instr_dout;
      npc_d     = npc_in;
      e_ctl_d   = e_dec;
      w_ctl_d   = w_dec;
      mem_ctl_d = m_dec;
      valid_d   = 1'b1;
      illegal_d = ill_dec;
    end
  end

  // Pipeline register; reset dominates a simultaneous capture
  always_ff @(posedge clock) begin
    if (!reset) begin
      ir_q      <= 16'h0000;
      npc_q     <= 16'h0000;
      e_ctl_q   <= 6'b000000;
      w_ctl_q   <= 2'b00;
      mem_ctl_q <= 1'b0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      npc_q     <= npc_d;
      e_ctl_q   <= e_ctl_d;
      w_ctl_q   <= w_ctl_d;
      mem_ctl_q <= mem_ctl_d;
      valid_q   <= valid_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef DECODE_INSTR_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Wrapping capture counter
  always_comb begin
    cnt_d = cnt_q;
    if (enable_decode) cnt_d = cnt_q + 16'd1;
  end

  // Counter register
  always_ff @(posedge clock) begin
    if (!reset) cnt_q <= 16'h0000;
    else        cnt_q <= cnt_d;
  end

  assign instr_count = cnt_q;
`endif

  assign ir           = ir_q;
  assign npc_out      = npc_q;
  assign E_control    = e_ctl_q;
  assign W_control    = w_ctl_q;
  assign mem_control  = mem_ctl_q;
  assign decode_valid = valid_q;
  assign illegal_op   = illegal_q;

endmodule

// File: tb/tb_lc3_decode.sv
// tb_lc3_decode: table-driven bench for lc3_decode. Each vector is driven on
// the falling edge, clocked in on the rising edge and checked 1 ns later.
module tb_lc3_decode;

  logic        clock;
  logic        reset;
  logic        enable_decode;
  logic [15:0] instr_dout;
  logic [15:0] npc_in;
  logic [15:0] ir;
  logic [15:0] npc_out;
  logic [5:0]  E_control;
  logic [1:0]  W_control;
  logic        mem_control;
  logic        decode_valid;
  logic        illegal_op;
`ifdef DECODE_INSTR_CNT_EN
  logic [15:0] instr_count;
`endif

  int checks = 0;
  int errors = 0;

  lc3_decode dut (
    .clock         (clock),
    .reset         (reset),
    .enable_decode (enable_decode),
    .instr_dout    (instr_dout),
    .npc_in        (npc_in),
    .ir            (ir),
    .npc_out       (npc_out),
    .E_control     (E_control),
    .W_control     (W_control),
    .mem_control   (mem_control),
    .decode_valid  (decode_valid),
`ifdef DECODE_INSTR_CNT_EN
    .illegal_op    (illegal_op),
    .instr_count   (instr_count)
`else
    .illegal_op    (illegal_op)
`endif
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [15:0] instr;
    logic [15:0] npc;
    logic [15:0] x_ir;
    logic [15:0] x_npc;
    logic [5:0]  x_e;
    logic [1:0]  x_w;
    logic        x_m;
    logic        x_v;
    logic        x_ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst_n, logic en, logic [15:0] instr, logic [15:0] npc,
                              logic [15:0] x_ir, logic [15:0] x_npc, logic [5:0] x_e,
                              logic [1:0] x_w, logic x_m, logic x_v, logic x_ill);
    vec_t v;
    v.rst_n = rst_n; v.en = en; v.instr = instr; v.npc = npc;
    v.x_ir = x_ir; v.x_npc = x_npc; v.x_e = x_e; v.x_w = x_w;
    v.x_m = x_m; v.x_v = x_v; v.x_ill = x_ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst_n, input logic en, input logic [15:0] instr,
                       input logic [15:0] npc);
    @(negedge clock);
    reset         = rst_n;
    enable_decode = en;
    instr_dout    = instr;
    npc_in        = npc;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; enable_decode = 1'b0; instr_dout = 16'h0000; npc_in = 16'h0000;

    // Reset held 3 cycles while enabled: nothing captured
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 1, 16'h1283, 16'h3001, 16'h0000, 16'h0000, 6'b000000, 2'b00, 0, 0, 0));
    // ADD reg / ADD imm
    vecs.push_back(mk(1, 1, 16'h1283, 16'h3001, 16'h1283, 16'h3001, 6'b000001, 2'b00, 0, 1, 0));
    vecs.push_back(mk(1, 1, 16'h1021, 16'h3002, 16'h1021, 16'h3002, 6'b000000, 2'b00, 0, 1, 0));
    // LDI, JMP, LEA back-to-back
    vecs.push_back(mk(1, 1, 16'hA5FF, 16'h3003, 16'hA5FF, 16'h3003, 6'b000110, 2'b01, 1, 1, 0));
    vecs.push_back(mk(1, 1, 16'hC0C0, 16'h3004, 16'hC0C0, 16'h3004, 6'b001100, 2'b00, 0, 1, 0));
    vecs.push_back(mk(1, 1, 16'hE002, 16'h3005, 16'hE002, 16'h3005, 6'b000110, 2'b10, 0, 1, 0));
    // AND imm (bit5=1), then 4-cycle stall with changing inputs
    vecs.push_back(mk(1, 1, 16'h5262, 16'h3006, 16'h5262, 16'h3006, 6'b010000, 2'b00, 0, 1, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 0, 16'h9FFF, 16'h4000 + 16'(i), 16'h5262, 16'h3006, 6'b010000, 2'b00, 0, 1, 0));
    // NOT after re-enable
    vecs.push_back(mk(1, 1, 16'h9FFF, 16'h3007, 16'h9FFF, 16'h3007, 6'b100000, 2'b00, 0, 1, 0));
    // Illegal then BR clears illegal
    vecs.push_back(mk(1, 1, 16'hD000, 16'h3008, 16'hD000, 16'h3008, 6'b000000, 2'b00, 0, 1, 1));
    vecs.push_back(mk(1, 1, 16'h0E05, 16'h3009, 16'h0E05, 16'h3009, 6'b000110, 2'b00, 0, 1, 0));
    // Reset mid-stream on an enable edge, then idle keeps valid low
    vecs.push_back(mk(0, 1, 16'h3000, 16'h300A, 16'h0000, 16'h0000, 6'b000000, 2'b00, 0, 0, 0));
    vecs.push_back(mk(1, 0, 16'h3000, 16'h300A, 16'h0000, 16'h0000, 6'b000000, 2'b00, 0, 0, 0));
    // Remaining opcodes
    vecs.push_back(mk(1, 1, 16'h7040, 16'h300B, 16'h7040, 16'h300B, 6'b001000, 2'b00, 0, 1, 0));
    vecs.push_back(mk(1, 1, 16'h3000, 16'h300C, 16'h3000, 16'h300C, 6'b000110, 2'b00, 0, 1, 0));
    vecs.push_back(mk(1, 1, 16'hB000, 16'h300D, 16'hB000, 16'h300D, 6'b000110, 2'b00, 1, 1, 0));
    vecs.push_back(mk(1, 1, 16'h2000, 16'h300E, 16'h2000, 16'h300E, 6'b000110, 2'b01, 0, 1, 0));
    vecs.push_back(mk(1, 1, 16'h6000, 16'h300F, 16'h6000, 16'h300F, 6'b001000, 2'b01, 0, 1, 0));
    vecs.push_back(mk(1, 1, 16'h5042, 16'h3010, 16'h5042, 16'h3010, 6'b010001, 2'b00, 0, 1, 0));
    vecs.push_back(mk(1, 1, 16'h4000, 16'h3011, 16'h4000, 16'h3011, 6'b000000, 2'b00, 0, 1, 1));
    vecs.push_back(mk(1, 1, 16'h8000, 16'h3012, 16'h8000, 16'h3012, 6'b000000, 2'b00, 0, 1, 1));
    vecs.push_back(mk(1, 1, 16'hF025, 16'h3013, 16'hF025, 16'h3013, 6'b000000, 2'b00, 0, 1, 1));
    vecs.push_back(mk(1, 1, 16'h1FFF, 16'hFFFF, 16'h1FFF, 16'hFFFF, 6'b000000, 2'b00, 0, 1, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].instr, vecs[i].npc);
      chk($sformatf("v%0d ir", i),          ir,                    vecs[i].x_ir);
      chk($sformatf("v%0d npc_out", i),     npc_out,               vecs[i].x_npc);
      chk($sformatf("v%0d E_control", i),   {10'd0, E_control},    {10'd0, vecs[i].x_e});
      chk($sformatf("v%0d W_control", i),   {14'd0, W_control},    {14'd0, vecs[i].x_w});
      chk($sformatf("v%0d mem_control", i), {15'd0, mem_control},  {15'd0, vecs[i].x_m});
      chk($sformatf("v%0d decode_valid", i),{15'd0, decode_valid}, {15'd0, vecs[i].x_v});
      chk($sformatf("v%0d illegal_op", i),  {15'd0, illegal_op},   {15'd0, vecs[i].x_ill});
    end

`ifdef DECODE_INSTR_CNT_EN
    // Counter: reset, 5 captures interleaved with 3 idles
    drive(0, 0, 16'h0000, 16'h0000);
    chk("cnt reset", instr_count, 16'd0);
    drive(1, 1, 16'h1283, 16'h0001);
    drive(1, 0, 16'h1283, 16'h0001);
    drive(1, 1, 16'hD000, 16'h0002);
    drive(1, 0, 16'hD000, 16'h0002);
    drive(1, 1, 16'h5262, 16'h0003);
    drive(1, 0, 16'h5262, 16'h0003);
    drive(1, 1, 16'hA5FF, 16'h0004);
    drive(1, 1, 16'hC0C0, 16'h0005);
    chk("cnt five", instr_count, 16'd5);
    // Run up to 0xFFFF then wrap
    for (int i = 0; i < 65530; i++) drive(1, 1, 16'h1021, 16'h0006);
    chk("cnt ffff", instr_count, 16'hFFFF);
    drive(1, 1, 16'h1021, 16'h0007);
    chk("cnt wrap", instr_count, 16'h0000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
